// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, byte-lane helpers.
package lsu_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_ST,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_e;

  // Byte lanes touched by an access of the given size at the given low address bits.
  function automatic logic [NUM_LANES-1:0] lane_mask(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    lane_mask = 4'b0001 << lo;
      SZ_H:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic: load extract/extend and store lane merge into the old word.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [NUM_LANES-1:0][LANE_W-1:0] rd_l, old_l, rep_l, st_l;
  logic [NUM_LANES-1:0]             mask;
  logic [7:0]                       b;
  logic [15:0]                      h;

  assign rd_l  = rdata;
  assign old_l = old_word;
  assign mask  = lane_mask(size, addr_lo);

  // Replicate right-aligned store data across every lane it could land in.
  always_comb begin
    case (size)
      SZ_B:    rep_l = {4{wdata[7:0]}};
      SZ_H:    rep_l = {2{wdata[15:0]}};
      default: rep_l = wdata;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_l[i] = mask[i] ? rep_l[i] : old_l[i];
  end
  assign st_data = st_l;

  assign b = rd_l[addr_lo];
  assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (size)
      SZ_B:    ld_data = {{24{~uns & b[7]}}, b};
      SZ_H:    ld_data = {{16{~uns & h[15]}}, h};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit driving a word-only dmem; sub-word stores use read-modify-write.
// Build option: LSU_MISALIGN_FAULT_EN faults misaligned half/word accesses.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enab,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state, state_nxt;
  size_e             size_q;
  logic              uns_q, fault_q, misalign, fault_now;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, old_q, result_q, ld_data, st_data;

`ifdef LSU_MISALIGN_FAULT_EN
  assign misalign = (req_size == SZ_H && req_addr[0]) ||
                    (req_size == SZ_W && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign fault_now = (req_size == SZ_RSV) || misalign;

  lsu_lane_merge u_lane (
    .size     (size_q),
    .uns      (uns_q),
    .addr_lo  (addr_q[1:0]),
    .rdata    (mem_rdata),
    .old_word (old_q),
    .wdata    (wdata_q),
    .ld_data  (ld_data),
    .st_data  (st_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_enab   = 1'b0;
    mem_wdata  = '0;
    mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        mem_addr  = '0;
        if (req_valid) begin
          if (fault_now)          state_nxt = S_RESP;
          else if (!req_we)       state_nxt = S_LD;
          else if (req_size == SZ_W) state_nxt = S_ST;
          else                    state_nxt = S_RMW_RD;
        end
      end
      S_LD:     state_nxt = S_RESP;
      S_ST: begin
        mem_enab  = 1'b1;
        mem_wdata = wdata_q;
        state_nxt = S_RESP;
      end
      S_RMW_RD: state_nxt = S_RMW_WR;
      S_RMW_WR: begin
        mem_enab  = 1'b1;
        mem_wdata = st_data;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      result_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          size_q  <= size_e'(req_size);
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          fault_q <= fault_now;
          if (fault_now) result_q <= '0;
        end
        S_LD:             result_q <= ld_data;
        S_ST, S_RMW_WR:   result_q <= '0;
        S_RMW_RD:         old_q    <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign resp_rdata = result_q;
  assign resp_fault = fault_q && (state == S_RESP);

endmodule

// File: tb/tb_lsu_rmw.sv
// Table-driven bench for lsu_rmw with a word-granular dmem model.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault, mem_enab;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:15] = '{0: 32'hCAFEF00D, 1: 32'h11223344, 2: 32'h8000FF7F, default: 32'h0};
  int enab_total = 0, resp_total = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_enab) mem[mem_addr[5:2]] <= mem_wdata;
  always @(negedge clk) begin
    if (mem_enab)   enab_total <= enab_total + 1;
    if (resp_valid) resp_total <= resp_total + 1;
  end

  lsu_rmw dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_enab(mem_enab),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_flt;
    int          exp_lat;
    int          exp_enab;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a request (waiting for req_ready), then count negedges until resp_valid.
  task automatic do_req(input vec_t v, output logic [31:0] rd, output logic flt,
                        output int lat, output int enabs);
    int n, e0;
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 8) begin @(negedge clk); n++; end
    chk({v.name, " ready"}, {31'b0, req_ready}, 32'd1);
    e0 = enab_total;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; rd = 'x; flt = 1'bx;
    while (lat < 8) begin
      @(negedge clk); lat++;
      if (resp_valid) begin rd = resp_rdata; flt = resp_fault; break; end
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL %s timeout: no resp_valid within 8 cycles", v.name);
    end
    #1 enabs = enab_total - e0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat, en, e0, r0;

    tv[0]  = '{"sb 5",    1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AB, 32'h0, 1'b0, 3, 1};
    tv[1]  = '{"lb 8",    1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 32'h0000007F, 1'b0, 2, 0};
    tv[2]  = '{"lb 9",    1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0};
    tv[3]  = '{"lbu 9",   1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 32'h000000FF, 1'b0, 2, 0};
    tv[4]  = '{"lh a",    1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'hFFFF8000, 1'b0, 2, 0};
    tv[5]  = '{"lhu a",   1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'h00008000, 1'b0, 2, 0};
    tv[6]  = '{"lh 8",    1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 32'hFFFFFF7F, 1'b0, 2, 0};
    tv[7]  = '{"sw c",    1'b1, 2'b10, 1'b0, 32'hC, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1};
    tv[8]  = '{"lw c",    1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0};
    tv[9]  = '{"rsv st",  1'b1, 2'b11, 1'b0, 32'h10, 32'h99999999, 32'h0, 1'b1, 1, 0};
`ifdef LSU_MISALIGN_FAULT_EN
    tv[10] = '{"lw 6",    1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0};
`else
    tv[10] = '{"lw 6",    1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h1122AB44, 1'b0, 2, 0};
`endif
    tv[11] = '{"sh e",    1'b1, 2'b01, 1'b0, 32'hE, 32'hFFFF1234, 32'h0, 1'b0, 3, 1};
    tv[12] = '{"lhu e",   1'b0, 2'b01, 1'b1, 32'hE, 32'h0, 32'h00001234, 1'b0, 2, 0};
    tv[13] = '{"lb f",    1'b0, 2'b00, 1'b0, 32'hF, 32'h0, 32'h00000012, 1'b0, 2, 0};

    #12;
    chk("rst req_ready",  {31'b0, req_ready},  32'd1);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst mem_addr",   mem_addr,   32'h0);
    chk("rst mem_enab",   {31'b0, mem_enab}, 32'd0);
    chk("rst mem_wdata",  mem_wdata,  32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Each request is issued as soon as the previous response is seen, so
    // consecutive requests are held across the RESP->IDLE edge.
    for (int i = 0; i < 14; i++) begin
      do_req(tv[i], rd, flt, lat, en);
      chk({tv[i].name, " rdata"}, rd, tv[i].exp_rd);
      chk({tv[i].name, " fault"}, {31'b0, flt}, {31'b0, tv[i].exp_flt});
      chk({tv[i].name, " latency"}, lat, tv[i].exp_lat);
      chk({tv[i].name, " enab cycles"}, en, tv[i].exp_enab);
    end
    chk("mem word 4", mem[1], 32'h1122AB44);
    chk("mem word c", mem[3], 32'h1234BEEF);
    chk("mem word 10 untouched", mem[4], 32'h0);

    // Reset while the sub-word store sits in RMW_RD.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h2; req_wdata = 32'h00005566; req_valid = 1'b1;
    e0 = enab_total; r0 = resp_total;
    @(posedge clk); #1 req_valid = 1'b0;
    chk("rmw_rd mem_addr", mem_addr, 32'h0);
    chk("rmw_rd req_ready", {31'b0, req_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst req_ready",  {31'b0, req_ready},  32'd1);
    chk("midrst mem_enab",   {31'b0, mem_enab},   32'd0);
    chk("midrst mem_wdata",  mem_wdata,  32'h0);
    chk("midrst resp_rdata", resp_rdata, 32'h0);
    chk("midrst resp_valid", {31'b0, resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst req_ready", {31'b0, req_ready}, 32'd1);
    chk("postrst no write",  enab_total - e0, 32'd0);
    chk("postrst no resp",   resp_total - r0, 32'd0);
    chk("postrst mem word 0", mem[0], 32'hCAFEF00D);
    do_req('{"lw 0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0}, rd, flt, lat, en);
    chk("lw 0 rdata", rd, 32'hCAFEF00D);
    chk("lw 0 latency", lat, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
